// File: rtl/unpool_if.sv
// Valid/ready/data stream bundle used for both the pixel input and the pixel output of unpool.
interface unpool_if #(
   parameter int unsigned Width = 1
) ();
   logic             valid;
   logic             ready;
   logic [Width-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/unpool.sv
// Streaming nearest-neighbour upsampler: each pixel is repeated KernelWidth times along the row,
// and each row is repeated KernelWidth times from a single line buffer.
module unpool #(
   parameter int unsigned KernelWidth = 2,
   parameter int unsigned WidthIn     = 1,
   parameter int unsigned LineWidthPx = 16
) (
   input  logic     clk_i,
   input  logic     reset_i,
   unpool_if.slave  in_if,
   unpool_if.master out_if
);
   localparam int unsigned WidthOut = WidthIn;
   localparam int unsigned RepW     = (KernelWidth > 1) ? $clog2(KernelWidth) : 1;
   localparam int unsigned ColW     = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
   localparam logic [RepW-1:0] RepLast = RepW'(KernelWidth - 1);
   localparam logic [RepW-1:0] RepOne  = RepW'(1);
   localparam logic [ColW-1:0] ColLast = ColW'(LineWidthPx - 1);
   localparam logic [ColW-1:0] ColOne  = ColW'(1);

   typedef enum logic {StPass, StReplay} state_e;

   state_e             state_q, state_d;
   logic               hold_vld_q, hold_vld_d;
   logic [WidthIn-1:0] hold_q, hold_d;
   logic [RepW-1:0]    hrep_q, hrep_d, vrep_q, vrep_d;
   logic [ColW-1:0]    col_q, col_d, wcol_q, wcol_d;
   logic [WidthIn-1:0] linebuf_q [LineWidthPx];

   logic                valid_out, in_rdy, out_fire, in_fire, last_rep, last_col;
   logic [WidthOut-1:0] data_out;

   assign valid_out = (state_q == StReplay) || hold_vld_q;
   assign data_out  = (state_q == StReplay) ? linebuf_q[col_q] : hold_q;
   assign out_fire  = valid_out && out_if.ready;
   assign last_rep  = (hrep_q == RepLast);
   assign last_col  = (col_q == ColLast);

   // A new pixel may slip in while the previous one drains its last replica, except at row end
   // when a replay follows.
   assign in_rdy  = !reset_i && (state_q == StPass) &&
                    (!hold_vld_q || (out_fire && last_rep && (!last_col || KernelWidth == 1)));
   assign in_fire = in_if.valid && in_rdy;

   assign in_if.ready  = in_rdy;
   assign out_if.valid = valid_out;
   assign out_if.data  = data_out;

   always_comb begin
      state_d    = state_q;
      hold_vld_d = hold_vld_q;
      hold_d     = hold_q;
      hrep_d     = hrep_q;
      vrep_d     = vrep_q;
      col_d      = col_q;
      wcol_d     = wcol_q;
      unique case (state_q)
         StPass: begin
            if (out_fire) begin
               hrep_d = last_rep ? '0 : hrep_q + RepOne;
               if (last_rep) begin
                  hold_vld_d = 1'b0;
                  if (last_col && KernelWidth > 1) begin
                     state_d = StReplay;
                     vrep_d  = RepOne;
                     col_d   = '0;
                  end
               end
            end
            if (in_fire) begin
               hold_d     = in_if.data;
               hold_vld_d = 1'b1;
               col_d      = wcol_q;
               wcol_d     = (wcol_q == ColLast) ? '0 : wcol_q + ColOne;
            end
         end
         StReplay: begin
            if (out_fire) begin
               hrep_d = last_rep ? '0 : hrep_q + RepOne;
               if (last_rep) begin
                  col_d = last_col ? '0 : col_q + ColOne;
                  if (last_col) begin
                     if (vrep_q == RepLast) begin
                        state_d = StPass;
                        vrep_d  = '0;
                     end else begin
                        vrep_d = vrep_q + RepOne;
                     end
                  end
               end
            end
         end
         default: state_d = StPass;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StPass;
         hold_vld_q <= 1'b0;
         hold_q     <= '0;
         hrep_q     <= '0;
         vrep_q     <= '0;
         col_q      <= '0;
         wcol_q     <= '0;
      end else begin
         state_q    <= state_d;
         hold_vld_q <= hold_vld_d;
         hold_q     <= hold_d;
         hrep_q     <= hrep_d;
         vrep_q     <= vrep_d;
         col_q      <= col_d;
         wcol_q     <= wcol_d;
      end
   end

   // Never cleared: every replay is preceded by a complete row write.
   always_ff @(posedge clk_i) begin
      if (in_fire) begin
         linebuf_q[wcol_q] <= in_if.data;
      end
   end
endmodule

// File: tb/tb_unpool.sv
// Bench for unpool: three configurations (K=2/W=4, K=3/W=2, K=1/W=4) checked against a
// row-replication model with directed and randomized handshakes.
module tb_unpool;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       vi [3];
   logic       ri [3];
   logic [7:0] di [3];
   logic       vo [3];
   logic       ro [3];
   logic [7:0] dq [3];

   int k_of [3] = '{2, 3, 1};
   int w_of [3] = '{4, 2, 4};
   int n_tests = 0;
   int n_fail  = 0;

   unpool_if #(.Width(8)) in0 ();
   unpool_if #(.Width(8)) out0 ();
   unpool_if #(.Width(8)) in1 ();
   unpool_if #(.Width(8)) out1 ();
   unpool_if #(.Width(8)) in2 ();
   unpool_if #(.Width(8)) out2 ();

   assign in0.valid = vi[0];  assign in0.data = di[0];  assign out0.ready = ri[0];
   assign in1.valid = vi[1];  assign in1.data = di[1];  assign out1.ready = ri[1];
   assign in2.valid = vi[2];  assign in2.data = di[2];  assign out2.ready = ri[2];
   assign ro[0] = in0.ready;  assign vo[0] = out0.valid;  assign dq[0] = out0.data;
   assign ro[1] = in1.ready;  assign vo[1] = out1.valid;  assign dq[1] = out1.data;
   assign ro[2] = in2.ready;  assign vo[2] = out2.valid;  assign dq[2] = out2.data;

   unpool #(.KernelWidth(2), .WidthIn(8), .LineWidthPx(4)) u_k2 (
      .clk_i(clk), .reset_i(rst), .in_if(in0), .out_if(out0));
   unpool #(.KernelWidth(3), .WidthIn(8), .LineWidthPx(2)) u_k3 (
      .clk_i(clk), .reset_i(rst), .in_if(in1), .out_if(out1));
   unpool #(.KernelWidth(1), .WidthIn(8), .LineWidthPx(4)) u_k1 (
      .clk_i(clk), .reset_i(rst), .in_if(in2), .out_if(out2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int sel, input logic [7:0] px[$], input int src,
                        input int rdy_pct, input int vld_pct);
      vi[sel] = (src < px.size()) && ($urandom_range(99) < vld_pct);
      di[sel] = vi[sel] ? px[src] : 8'($urandom);
      ri[sel] = $urandom_range(99) < rdy_pct;
   endtask

   // Streams px (whole rows) into DUT sel; expected output is each row's pixels repeated K times,
   // the whole row repeated K times. With full handshakes, exact cycle timing is also checked.
   task automatic run_stream(input int sel, input logic [7:0] px[$], input int rdy_pct,
                             input int vld_pct, input int abort_n);
      int         k, w, period, total, src, n_out, cyc, budget, opr;
      logic [7:0] exp_q[$];
      logic [7:0] hold_val;
      bit         full, hold_chk, acc;
      k      = k_of[sel];
      w      = w_of[sel];
      opr    = k * w * k;
      period = (k == 1) ? w : opr + 1;
      full   = (rdy_pct >= 100) && (vld_pct >= 100);
      for (int r = 0; r < px.size() / w; r++)
         for (int v = 0; v < k; v++)
            for (int c = 0; c < w; c++)
               for (int h = 0; h < k; h++) exp_q.push_back(px[r * w + c]);
      total    = (abort_n > 0) ? abort_n : exp_q.size();
      src      = 0;
      n_out    = 0;
      cyc      = 0;
      hold_chk = 1'b0;
      hold_val = '0;
      budget   = 100 + 20 * total;
      @(posedge clk);
      #1;
      drive(sel, px, src, rdy_pct, vld_pct);
      while (n_out < total && cyc < budget) begin
         @(negedge clk);
         if (hold_chk) begin
            check("hold_valid", 32'(vo[sel]), 32'd1);
            check("hold_data", 32'(dq[sel]), 32'(hold_val));
         end
         hold_chk = vo[sel] && !ri[sel];
         hold_val = dq[sel];
         if (vo[sel] && ri[sel]) begin
            check("data", 32'(dq[sel]), 32'(exp_q.pop_front()));
            if (full) check("out_cycle", cyc, (n_out / opr) * period + 1 + (n_out % opr));
            n_out++;
         end
         acc = vi[sel] && ro[sel];
         if (acc && full) check("accept_cycle", cyc, (src / w) * period + (src % w) * k);
         @(posedge clk);
         #1;
         if (acc) src++;
         cyc++;
         drive(sel, px, src, rdy_pct, vld_pct);
      end
      check("out_count", n_out, total);
      vi[sel] = 1'b0;
      if (abort_n == 0) begin
         ri[sel] = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_extra_out", 32'(vo[sel]), 32'd0);
         end
      end
      ri[sel] = 1'b0;
   endtask

   logic [7:0] row_q[$];

   task automatic rand_rows(input int n);
      row_q = {};
      for (int i = 0; i < n; i++) row_q.push_back(8'($urandom));
   endtask

   initial begin
      for (int s = 0; s < 3; s++) begin
         vi[s] = 1'b0;
         ri[s] = 1'b0;
         di[s] = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check("reset_ready", 32'(ro[s]), 32'd0);
         check("reset_valid", 32'(vo[s]), 32'd0);
         check("reset_data", 32'(dq[s]), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int s = 0; s < 3; s++) ri[s] = 1'b1;
      repeat (6) begin
         @(negedge clk);
         for (int s = 0; s < 3; s++) begin
            check("idle_ready", 32'(ro[s]), 32'd1);
            check("idle_valid", 32'(vo[s]), 32'd0);
         end
      end
      for (int s = 0; s < 3; s++) ri[s] = 1'b0;

      row_q = {8'd1, 8'd2, 8'd3, 8'd4};
      run_stream(0, row_q, 100, 100, 0);
      row_q = {8'd5, 8'd9, 8'd7, 8'd8};
      run_stream(1, row_q, 100, 100, 0);
      row_q = {8'd1, 8'd2, 8'd3, 8'd4};
      run_stream(0, row_q, 50, 60, 0);
      rand_rows(12);
      run_stream(0, row_q, 50, 70, 0);
      rand_rows(6);
      run_stream(1, row_q, 60, 50, 0);

      row_q = {8'd1, 8'd2, 8'd3, 8'd4};
      run_stream(0, row_q, 100, 100, 10);
      rst = 1'b1;
      @(negedge clk);
      check("midreplay_reset_ready", 32'(ro[0]), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("after_reset_valid", 32'(vo[0]), 32'd0);
      check("after_reset_ready", 32'(ro[0]), 32'd1);
      row_q = {8'd6, 8'd6, 8'd7, 8'd7};
      run_stream(0, row_q, 100, 100, 0);

      rand_rows(12);
      run_stream(2, row_q, 100, 100, 0);
      rand_rows(12);
      run_stream(2, row_q, 50, 50, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
